// File: rtl/mem_port_arbiter.sv
// Two-requester memory port arbiter: data over fetch, one access in flight.
// Registered request, one-cycle completion pulses, ack timeout, flush drop.
module mem_port_arbiter #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic        clk,
    input  logic        reset_x,
    input  logic        i_ifReq,
    input  logic [31:0] i_ifAddr,
    input  logic        i_dReq,
    input  logic        i_dWrite,
    input  logic [1:0]  i_dSize,
    input  logic [31:0] i_dAddr,
    input  logic [31:0] i_dWdata,
    input  logic        i_flush,
    input  logic        i_memAck,
    input  logic [31:0] i_memRdata,
    output logic        o_memReq,
    output logic        o_memWrite,
    output logic [1:0]  o_memSize,
    output logic [31:0] o_memAddr,
    output logic [31:0] o_memWdata,
    output logic        o_ifValid,
    output logic [31:0] o_ifRdata,
    output logic        o_dValid,
    output logic [31:0] o_dRdata,
    output logic        o_stallF,
    output logic        o_stallM,
    output logic        o_busErr
);
    typedef enum logic [1:0] {
        IDLE,
        BUSY_IF,
        BUSY_D
    } state_t;

    state_t      state;
    state_t      stateNxt;
    logic [7:0]  waitCnt;
    logic        drop;
    logic [31:0] addrR;
    logic [31:0] wdataR;
    logic        writeR;
    logic [1:0]  sizeR;
    logic        ifValidR;
    logic        dValidR;
    logic        busErrR;
    logic [31:0] ifRdataR;
    logic [31:0] dRdataR;

    logic dElig;
    logic ifElig;
    logic grantD;
    logic grantIf;
    logic busy;
    logic timeout;
    logic finish;
    logic dropNow;

    always_comb begin
        dElig    = i_dReq & ~dValidR;
        ifElig   = i_ifReq & ~ifValidR;
        grantD   = (state == IDLE) & dElig;
        grantIf  = (state == IDLE) & ~dElig & ifElig & ~i_flush;
        busy     = (state != IDLE);
        timeout  = busy & ~i_memAck & (waitCnt == TIMEOUT);
        finish   = busy & (i_memAck | timeout);
        dropNow  = drop | i_flush;
        stateNxt = state;
        unique case (state)
            IDLE: begin
                if (grantD) begin
                    stateNxt = BUSY_D;
                end else if (grantIf) begin
                    stateNxt = BUSY_IF;
                end
            end
            BUSY_IF, BUSY_D: begin
                if (finish) begin
                    stateNxt = IDLE;
                end
            end
            default: stateNxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            state <= IDLE;
        end else begin
            state <= stateNxt;
        end
    end

    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            waitCnt  <= '0;
            drop     <= 1'b0;
            addrR    <= '0;
            wdataR   <= '0;
            writeR   <= 1'b0;
            sizeR    <= '0;
            ifValidR <= 1'b0;
            dValidR  <= 1'b0;
            busErrR  <= 1'b0;
            ifRdataR <= '0;
            dRdataR  <= '0;
        end else begin
            ifValidR <= 1'b0;
            dValidR  <= 1'b0;
            busErrR  <= 1'b0;
            if (grantD | grantIf) begin
                addrR   <= grantD ? i_dAddr : i_ifAddr;
                writeR  <= grantD & i_dWrite;
                sizeR   <= grantD ? i_dSize : 2'b10;
                wdataR  <= grantD ? i_dWdata : '0;
                waitCnt <= '0;
            end else if (busy & ~finish) begin
                waitCnt <= waitCnt + 8'd1;
            end
            if ((state == BUSY_IF) & i_flush) begin
                drop <= 1'b1;
            end
            // A flush landing in the ack cycle still kills the fetch pulse
            if (finish) begin
                drop    <= 1'b0;
                busErrR <= timeout;
                if (state == BUSY_D) begin
                    dValidR <= 1'b1;
                    dRdataR <= (writeR | timeout) ? '0 : i_memRdata;
                end else if (!dropNow) begin
                    ifValidR <= 1'b1;
                    ifRdataR <= timeout ? '0 : i_memRdata;
                end
            end
        end
    end

    assign o_memReq   = busy;
    assign o_memWrite = busy & writeR;
    assign o_memSize  = busy ? sizeR : 2'b00;
    assign o_memAddr  = busy ? addrR : '0;
    assign o_memWdata = busy ? wdataR : '0;
    assign o_ifValid  = ifValidR;
    assign o_ifRdata  = ifRdataR;
    assign o_dValid   = dValidR;
    assign o_dRdata   = dRdataR;
    assign o_busErr   = busErrR;
    assign o_stallF   = i_ifReq & ~ifValidR;
    assign o_stallM   = i_dReq & ~dValidR;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic
// checked every cycle against a transaction-level reference model.
module tb_mem_port_arbiter;
    localparam int TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        reset_x;
    logic        ifReq;
    logic [31:0] ifAddr;
    logic        dReq;
    logic        dWrite;
    logic [1:0]  dSize;
    logic [31:0] dAddr;
    logic [31:0] dWdata;
    logic        flush;
    logic        memAck;
    logic [31:0] memRdata;
    logic        memReq;
    logic        memWrite;
    logic [1:0]  memSize;
    logic [31:0] memAddr;
    logic [31:0] memWdata;
    logic        ifValid;
    logic [31:0] ifRdata;
    logic        dValid;
    logic [31:0] dRdata;
    logic        stallF;
    logic        stallM;
    logic        busErr;

    int nTests = 0;
    int nFail  = 0;

    // model: owner 0 = free, 1 = fetch, 2 = data
    int          owner;
    int          waited;
    bit          drop;
    logic [31:0] mAddr;
    logic [31:0] mWdata;
    bit          mWrite;
    logic [1:0]  mSize;
    bit          eIfV;
    bit          eDV;
    bit          eErr;
    logic [31:0] eIfR;
    logic [31:0] eDR;

    mem_port_arbiter dut (
        .clk        (clk),
        .reset_x    (reset_x),
        .i_ifReq    (ifReq),
        .i_ifAddr   (ifAddr),
        .i_dReq     (dReq),
        .i_dWrite   (dWrite),
        .i_dSize    (dSize),
        .i_dAddr    (dAddr),
        .i_dWdata   (dWdata),
        .i_flush    (flush),
        .i_memAck   (memAck),
        .i_memRdata (memRdata),
        .o_memReq   (memReq),
        .o_memWrite (memWrite),
        .o_memSize  (memSize),
        .o_memAddr  (memAddr),
        .o_memWdata (memWdata),
        .o_ifValid  (ifValid),
        .o_ifRdata  (ifRdata),
        .o_dValid   (dValid),
        .o_dRdata   (dRdata),
        .o_stallF   (stallF),
        .o_stallM   (stallM),
        .o_busErr   (busErr)
    );

    always #5 clk = ~clk;

    task automatic checkEq(input string tag,
                           input logic [31:0] got,
                           input logic [31:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s @%0t: got %h expected %h",
                     tag, $time, got, exp);
        end
    endtask

    task automatic modelReset();
        owner  = 0;
        waited = 0;
        drop   = 0;
        mAddr  = '0;
        mWdata = '0;
        mWrite = 0;
        mSize  = '0;
        eIfV   = 0;
        eDV    = 0;
        eErr   = 0;
        eIfR   = '0;
        eDR    = '0;
    endtask

    task automatic modelStep();
        bit          nIfV;
        bit          nDV;
        bit          nErr;
        bit          done;
        logic [31:0] data;
        nIfV = 0;
        nDV  = 0;
        nErr = 0;
        done = 0;
        data = memRdata;
        if (owner == 0) begin
            if (dReq && !eDV) begin
                owner  = 2;
                mAddr  = dAddr;
                mWrite = dWrite;
                mSize  = dSize;
                mWdata = dWdata;
                waited = 0;
            end else if (ifReq && !eIfV && !flush) begin
                owner  = 1;
                mAddr  = ifAddr;
                mWrite = 0;
                mSize  = 2'b10;
                mWdata = '0;
                waited = 0;
            end
        end else begin
            if (owner == 1 && flush) drop = 1;
            if (memAck) begin
                done = 1;
            end else if (waited == TIMEOUT) begin
                done = 1;
                nErr = 1;
                data = '0;
            end else begin
                waited++;
            end
            if (done) begin
                if (owner == 2) begin
                    nDV = 1;
                    eDR = mWrite ? 32'h0 : data;
                end else if (!drop) begin
                    nIfV = 1;
                    eIfR = data;
                end
                owner = 0;
                drop  = 0;
            end
        end
        eIfV = nIfV;
        eDV  = nDV;
        eErr = nErr;
    endtask

    task automatic checkOutputs();
        bit b;
        b = (owner != 0);
        checkEq("memReq", memReq, b);
        checkEq("memAddr", memAddr, b ? mAddr : 32'h0);
        checkEq("memWrite", memWrite, b & mWrite);
        checkEq("memSize", memSize, b ? mSize : 2'b00);
        checkEq("memWdata", memWdata, b ? mWdata : 32'h0);
        checkEq("ifValid", ifValid, eIfV);
        checkEq("ifRdata", ifRdata, eIfR);
        checkEq("dValid", dValid, eDV);
        checkEq("dRdata", dRdata, eDR);
        checkEq("busErr", busErr, eErr);
        checkEq("stallF", stallF, ifReq & ~eIfV);
        checkEq("stallM", stallM, dReq & ~eDV);
    endtask

    task automatic tick();
        @(posedge clk);
        modelStep();
        #1;
        checkOutputs();
    endtask

    task automatic clearInputs();
        ifReq    = 0;
        ifAddr   = '0;
        dReq     = 0;
        dWrite   = 0;
        dSize    = '0;
        dAddr    = '0;
        dWdata   = '0;
        flush    = 0;
        memAck   = 0;
        memRdata = '0;
    endtask

    task automatic idle(input int n);
        clearInputs();
        repeat (n) tick();
    endtask

    task automatic randomInputs();
        if (!ifReq || eIfV || flush) begin
            ifReq  = ($urandom_range(0, 2) == 0);
            ifAddr = $urandom & 32'hFFFF_FFFC;
        end
        if (!dReq || eDV) begin
            dReq   = ($urandom_range(0, 2) == 0);
            dWrite = $urandom_range(0, 1);
            dSize  = 2'($urandom_range(0, 2));
            dAddr  = $urandom;
            dWdata = $urandom;
        end
        flush    = ($urandom_range(0, 7) == 0);
        memAck   = ($urandom_range(0, 2) == 0);
        memRdata = $urandom;
    endtask

    initial begin
        int n;
        clearInputs();
        modelReset();
        reset_x = 0;
        #1;
        checkOutputs();
        @(negedge clk);
        reset_x = 1;
        idle(2);

        ifReq  = 1;
        ifAddr = 32'h100;
        tick();
        checkEq("f_addr", memAddr, 32'h100);
        tick();
        tick();
        memAck   = 1;
        memRdata = 32'h13;
        tick();
        checkEq("f_valid", ifValid, 1);
        checkEq("f_rdata", ifRdata, 32'h13);
        checkEq("f_stallF", stallF, 0);
        clearInputs();
        tick();
        checkEq("f_pulse", ifValid, 0);
        checkEq("f_hold", ifRdata, 32'h13);
        idle(1);

        ifReq  = 1;
        ifAddr = 32'h400;
        dReq   = 1;
        dAddr  = 32'h200;
        tick();
        checkEq("pr_addrD", memAddr, 32'h200);
        memAck   = 1;
        memRdata = 32'h55;
        tick();
        checkEq("pr_dValid", dValid, 1);
        memAck = 0;
        dReq   = 0;
        tick();
        checkEq("pr_b2b", memReq, 1);
        checkEq("pr_addrF", memAddr, 32'h400);
        memAck = 1;
        tick();
        checkEq("pr_ifValid", ifValid, 1);
        idle(2);

        dReq   = 1;
        dWrite = 1;
        dSize  = 2'b00;
        dAddr  = 32'h300;
        dWdata = 32'hDEADBEEF;
        tick();
        checkEq("st_write", memWrite, 1);
        checkEq("st_wdata", memWdata, 32'hDEADBEEF);
        checkEq("st_size", memSize, 2'b00);
        memAck   = 1;
        memRdata = 32'h12345678;
        tick();
        checkEq("st_valid", dValid, 1);
        checkEq("st_rdata", dRdata, 0);
        idle(2);

        dReq  = 1;
        dAddr = 32'h500;
        tick();
        n = 0;
        while (!busErr && n < 300) begin
            tick();
            n++;
        end
        checkEq("to_cycles", n, TIMEOUT + 1);
        checkEq("to_valid", dValid, 1);
        checkEq("to_rdata", dRdata, 0);
        checkEq("to_idle", memReq, 0);
        idle(2);

        dReq  = 1;
        dAddr = 32'h504;
        tick();
        repeat (TIMEOUT) tick();
        memAck   = 1;
        memRdata = 32'hCAFE0001;
        tick();
        checkEq("ta_valid", dValid, 1);
        checkEq("ta_err", busErr, 0);
        checkEq("ta_rdata", dRdata, 32'hCAFE0001);
        idle(2);

        ifReq  = 1;
        ifAddr = 32'h600;
        tick();
        flush = 1;
        tick();
        flush    = 0;
        ifReq    = 0;
        memAck   = 1;
        memRdata = 32'h77;
        tick();
        checkEq("fl_valid", ifValid, 0);
        checkEq("fl_idle", memReq, 0);
        idle(2);

        dReq  = 1;
        dAddr = 32'h700;
        tick();
        tick();
        #2;
        reset_x = 0;
        #1;
        checkEq("rst_memReq", memReq, 0);
        checkEq("rst_addr", memAddr, 0);
        modelReset();
        clearInputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_x = 1;
        memAck  = 1;
        tick();
        checkEq("rst_noValid", dValid, 0);
        idle(3);

        for (int c = 0; c < 3000; c++) begin
            randomInputs();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule
